// File: rtl/clock_pkg.sv
// clock_pkg: shared widths, time struct and load-validity helper for the time-of-day counter
package clock_pkg;
  localparam int HOUR_W        = 5;
  localparam int MIN_W         = 6;
  localparam int SEC_W         = 6;
  localparam int SECS_PER_MIN  = 60;
  localparam int MINS_PER_HOUR = 60;
  typedef struct packed {
    logic [HOUR_W-1:0] hours;
    logic [MIN_W-1:0]  minutes;
    logic [SEC_W-1:0]  seconds;
  } time_t;
  function automatic logic valid_hm(input logic [HOUR_W-1:0] h, input logic [MIN_W-1:0] m, input int hpd);
    return (int'(h) < hpd) && (int'(m) < MINS_PER_HOUR);
  endfunction
endpackage

// File: rtl/mod_counter.sv
// mod_counter: loadable modulo counter whose wrap output chains into the next stage
module mod_counter #(
  parameter int MODULUS = 60,
  parameter int WIDTH   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);
  assign wrap = inc && (count == WIDTH'(MODULUS - 1));
  // load wins over increment; increment wraps to zero at the top of the range
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (load) count <= load_val;
    else if (inc) count <= wrap ? '0 : count + 1'b1;
endmodule

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: wall-clock h:m:s from divided_clk edges with alarm; SNOOZE_EN adds snooze
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int HOURS_PER_DAY = 24,
  parameter int SNOOZE_MIN    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_in,
  input  logic              set_time,
  input  logic              set_alarm,
  input  logic [HOUR_W-1:0] set_hours,
  input  logic [MIN_W-1:0]  set_minutes,
  input  logic              alarm_en,
  input  logic              alarm_ack,
  input  logic              snooze,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic              alarm_ring
);
  logic              r_tick_prev;
  logic              r_upd;
  logic              r_ring;
  logic [HOUR_W-1:0] r_alm_h;
  logic [MIN_W-1:0]  r_alm_m;
  logic              w_sec_tick;
  logic              w_set_ok;
  logic              w_alm_ok;
  logic              w_sec_inc;
  logic              w_sec_wrap;
  logic              w_min_wrap;
  logic              w_hour_wrap;
  logic              w_alm_hit;
  logic              w_snz_hit;
  logic              w_clear;
  time_t             w_now;

  assign w_sec_tick = tick_in & ~r_tick_prev;
  assign w_set_ok   = set_time & valid_hm(set_hours, set_minutes, HOURS_PER_DAY);
  assign w_alm_ok   = set_alarm & valid_hm(set_hours, set_minutes, HOURS_PER_DAY);
  assign w_sec_inc  = w_sec_tick & ~w_set_ok;

  mod_counter #(.MODULUS(SECS_PER_MIN), .WIDTH(SEC_W)) u_sec (
    .clk(clk), .reset(reset), .inc(w_sec_inc), .load(w_set_ok),
    .load_val('0), .count(seconds), .wrap(w_sec_wrap));
  mod_counter #(.MODULUS(MINS_PER_HOUR), .WIDTH(MIN_W)) u_min (
    .clk(clk), .reset(reset), .inc(w_sec_wrap), .load(w_set_ok),
    .load_val(set_minutes), .count(minutes), .wrap(w_min_wrap));
  mod_counter #(.MODULUS(HOURS_PER_DAY), .WIDTH(HOUR_W)) u_hour (
    .clk(clk), .reset(reset), .inc(w_min_wrap), .load(w_set_ok),
    .load_val(set_hours), .count(hours), .wrap(w_hour_wrap));

  assign w_now      = '{hours: hours, minutes: minutes, seconds: seconds};
  assign w_alm_hit  = r_upd & alarm_en & (w_now == time_t'{hours: r_alm_h, minutes: r_alm_m, seconds: '0});
  assign alarm_ring = r_ring;

  // edge history and a flag marking the first cycle after the counters took a new value
  always_ff @(posedge clk)
    if (reset) begin
      r_tick_prev <= 1'b0;
      r_upd       <= 1'b0;
    end else begin
      r_tick_prev <= tick_in;
      r_upd       <= w_sec_inc | w_set_ok;
    end

  // alarm time register, loaded only by a valid set_alarm
  always_ff @(posedge clk)
    if (reset) begin
      r_alm_h <= '0;
      r_alm_m <= '0;
    end else if (w_alm_ok) begin
      r_alm_h <= set_hours;
      r_alm_m <= set_minutes;
    end

  // ring latch: any clear source beats a simultaneous match
  always_ff @(posedge clk)
    if (reset) r_ring <= 1'b0;
    else r_ring <= w_clear ? 1'b0 : ((w_alm_hit | w_snz_hit) ? 1'b1 : r_ring);

`ifdef SNOOZE_EN
  logic              r_snz_pend;
  logic [HOUR_W-1:0] r_snz_h;
  logic [MIN_W-1:0]  r_snz_m;
  logic [MIN_W:0]    w_msum;
  logic              w_mwrap;
  logic [HOUR_W-1:0] w_tgt_h;
  logic [MIN_W-1:0]  w_tgt_m;
  logic              w_snz_cancel;
  assign w_msum       = {1'b0, minutes} + (MIN_W + 1)'(SNOOZE_MIN);
  assign w_mwrap      = w_msum >= (MIN_W + 1)'(MINS_PER_HOUR);
  assign w_tgt_m      = w_mwrap ? MIN_W'(w_msum - (MIN_W + 1)'(MINS_PER_HOUR)) : w_msum[MIN_W-1:0];
  assign w_tgt_h      = !w_mwrap ? hours : (hours == HOUR_W'(HOURS_PER_DAY - 1)) ? '0 : hours + 1'b1;
  assign w_snz_cancel = alarm_ack | ~alarm_en | set_alarm | set_time;
  assign w_snz_hit    = r_snz_pend & r_upd & alarm_en & (w_now == time_t'{hours: r_snz_h, minutes: r_snz_m, seconds: '0});
  assign w_clear      = alarm_ack | ~alarm_en | (snooze & r_ring);
  // snooze target capture; cancelled by ack, disarm or any load, consumed when it fires
  always_ff @(posedge clk)
    if (reset) begin
      r_snz_pend <= 1'b0;
      r_snz_h    <= '0;
      r_snz_m    <= '0;
    end else if (w_snz_cancel) r_snz_pend <= 1'b0;
    else if (snooze && r_ring) begin
      r_snz_pend <= 1'b1;
      r_snz_h    <= w_tgt_h;
      r_snz_m    <= w_tgt_m;
    end else if (w_snz_hit) r_snz_pend <= 1'b0;
`else
  logic w_unused;
  assign w_snz_hit = 1'b0;
  assign w_clear   = alarm_ack | ~alarm_en;
  assign w_unused  = snooze | (SNOOZE_MIN != 0) | w_hour_wrap;
`endif

`ifdef SNOOZE_EN
  logic w_unused_wrap;
  assign w_unused_wrap = w_hour_wrap;
`endif
endmodule

// File: tb/tb_time_of_day_counter.sv
// tb_time_of_day_counter: scoreboard bench; stimulus queues expected outputs, monitor compares each cycle
module tb_time_of_day_counter;
  logic       clk = 0, reset = 1, tick_in = 0, set_time = 0, set_alarm = 0;
  logic       alarm_en = 0, alarm_ack = 0, snooze = 0;
  logic [4:0] set_hours = 0, hours;
  logic [5:0] set_minutes = 0, minutes, seconds;
  logic       alarm_ring;
  int         n_vec = 0, n_err = 0;
  int         mh = 0, mm = 0, ms = 0;

  typedef struct {
    string nm;
    int    h, m, s;
    logic  r;
    bit    use_r;
  } exp_t;
  exp_t sb[$];

  time_of_day_counter dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .set_time(set_time), .set_alarm(set_alarm),
    .set_hours(set_hours), .set_minutes(set_minutes), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
    .snooze(snooze), .hours(hours), .minutes(minutes), .seconds(seconds), .alarm_ring(alarm_ring));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial forever begin
    @(negedge clk);
    while (sb.size() > 0) begin
      automatic exp_t e = sb.pop_front();
      n_vec++;
      if (int'(hours) != e.h || int'(minutes) != e.m || int'(seconds) != e.s || (e.use_r && alarm_ring !== e.r)) begin
        n_err++;
        $display("FAIL %s: got %0d:%0d:%0d ring=%b, want %0d:%0d:%0d ring=%b", e.nm,
                 hours, minutes, seconds, alarm_ring, e.h, e.m, e.s, e.use_r ? e.r : alarm_ring);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_t(input string nm, input int h, input int m, input int s, input logic r, input bit ur);
    sb.push_back('{nm, h, m, s, r, ur});
  endtask

  task automatic adv();
    ms++;
    if (ms == 60) begin ms = 0; mm++; end
    if (mm == 60) begin mm = 0; mh++; end
    if (mh == 24) mh = 0;
  endtask

  task automatic tick();
    expect_t("pre_tick", mh, mm, ms, 0, 0);
    tick_in = 1;
    step();
    adv();
    expect_t("tick", mh, mm, ms, 0, 0);
    tick_in = 0;
    step();
    expect_t("tick_low", mh, mm, ms, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_t(input int h, input int m);
    set_time = 1; set_hours = 5'(h); set_minutes = 6'(m);
    step();
    set_time = 0;
    if (h < 24 && m < 60) begin mh = h; mm = m; ms = 0; end
    expect_t("set_time", mh, mm, ms, 0, 0);
  endtask

  task automatic set_a(input int h, input int m);
    set_alarm = 1; set_hours = 5'(h); set_minutes = 6'(m);
    step();
    set_alarm = 0;
  endtask

  task automatic ack();
    alarm_ack = 1;
    step();
    alarm_ack = 0;
    expect_t("ack", mh, mm, ms, 0, 1);
  endtask

  initial begin
    repeat (3) step();
    expect_t("reset", 0, 0, 0, 0, 1);
    reset = 0;
    step();
    ticks(61);
    expect_t("t61", 0, 1, 1, 0, 1);
    tick_in = 1;
    step();
    adv();
    expect_t("hold_first", 0, 1, 2, 0, 1);
    repeat (5) begin step(); expect_t("hold_high", 0, 1, 2, 0, 1); end
    tick_in = 0;
    step();
    expect_t("hold_low", 0, 1, 2, 0, 1);
    set_t(23, 59);
    expect_t("set_2359", 23, 59, 0, 0, 1);
    ticks(59);
    expect_t("pre_roll", 23, 59, 59, 0, 1);
    tick();
    expect_t("rollover", 0, 0, 0, 0, 1);
    set_t(24, 10);
    expect_t("bad_hour", 0, 0, 0, 0, 1);
    set_t(5, 60);
    expect_t("bad_min", 0, 0, 0, 0, 1);
    set_time = 1; set_hours = 24; set_minutes = 10; tick_in = 1;
    step();
    adv();
    expect_t("bad_set_tick", 0, 0, 1, 0, 1);
    set_time = 0; tick_in = 0;
    step();
    set_time = 1; set_hours = 7; set_minutes = 30; tick_in = 1;
    step();
    mh = 7; mm = 30; ms = 0;
    expect_t("set_beats_tick", 7, 30, 0, 0, 1);
    set_time = 0; tick_in = 0;
    step();
    expect_t("tick_dropped", 7, 30, 0, 0, 1);
    set_a(6, 0);
    expect_t("set_alarm_keeps_time", 7, 30, 0, 0, 1);
    alarm_en = 1;
    set_t(5, 59);
    ticks(59);
    expect_t("pre_alarm", 5, 59, 59, 0, 1);
    tick_in = 1;
    step();
    adv();
    expect_t("match_cycle", 6, 0, 0, 0, 1);
    tick_in = 0;
    step();
    expect_t("ring", 6, 0, 0, 1, 1);
    step();
    expect_t("ring_held", 6, 0, 0, 1, 1);
    ack();
    step();
    expect_t("ack_stays", 6, 0, 0, 0, 1);
    alarm_en = 0;
    set_t(5, 59);
    ticks(61);
    expect_t("en_off", 6, 0, 1, 0, 1);
    alarm_en = 1;
    set_t(6, 0);
    step();
    expect_t("set_match", 6, 0, 0, 1, 1);
    alarm_en = 0;
    step();
    expect_t("en_clear", 6, 0, 0, 0, 1);
    alarm_en = 1;
    step();
    expect_t("no_rering", 6, 0, 0, 0, 1);
`ifdef SNOOZE_EN
    set_t(5, 59);
    ticks(60);
    step();
    expect_t("snz_ring", 6, 0, 0, 1, 1);
    snooze = 1;
    step();
    snooze = 0;
    expect_t("snz_quiet", 6, 0, 0, 0, 1);
    ticks(299);
    expect_t("snz_pre", 6, 4, 59, 0, 1);
    tick();
    step();
    expect_t("snz_ring2", 6, 5, 0, 1, 1);
    ack();
    set_t(5, 59);
    ticks(60);
    step();
    expect_t("snz_ring3", 6, 0, 0, 1, 1);
    snooze = 1;
    step();
    snooze = 0;
    ack();
    ticks(300);
    step();
    expect_t("snz_cancel", 6, 5, 0, 0, 1);
`endif
    set_t(5, 59);
    ticks(90);
    expect_t("ring_630", 6, 0, 30, 1, 1);
    reset = 1;
    step();
    expect_t("reset_mid", 0, 0, 0, 0, 1);
    reset = 0;
    mh = 0; mm = 0; ms = 0;
    tick();
    expect_t("resume", 0, 0, 1, 0, 1);
    set_t(0, 0);
    step();
    expect_t("alarm_reset", 0, 0, 0, 1, 1);
    ack();
    for (int i = 0; i < 10 && sb.size() > 0; i++) step();
    step();
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
